// File: rtl/ram_access_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ram_access_ctrl_if
// Purpose  : Request/response/fill channels plus single-port RAM pins seen
//            by ram_access_ctrl.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface ram_access_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             init_start;
  logic [WIDTH-1:0] init_value;
  logic             init_busy;
  logic [WIDTH-1:0] ram_data_in;
  logic             ram_read_enable;
  logic             ram_write_enable;
  logic [AW-1:0]    ram_address;
  logic [WIDTH-1:0] ram_data_out;

  // Host and RAM side together, as seen from outside the controller
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           init_start, init_value, ram_data_out,
    input  req_ready, rsp_valid, rsp_rdata, init_busy,
           ram_data_in, ram_read_enable, ram_write_enable, ram_address
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           init_start, init_value, ram_data_out,
    output req_ready, rsp_valid, rsp_rdata, init_busy,
           ram_data_in, ram_read_enable, ram_write_enable, ram_address
  );
endinterface
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ram_access_ctrl
// Purpose  : One-at-a-time valid/ready front end for a single-port RAM with
//            registered read data, plus a hardware constant-fill mode.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module ram_access_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  ram_access_ctrl_if.slave  bus
);

  localparam int            AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RSP     = 3'd4,
    S_INIT    = 3'd5
  } state_t;

  state_t           r_state,      w_state_nxt;
  logic             r_ram_we,     w_ram_we_nxt;
  logic             r_ram_re,     w_ram_re_nxt;
  logic [AW-1:0]    r_ram_addr,   w_ram_addr_nxt;
  logic [WIDTH-1:0] r_ram_din,    w_ram_din_nxt;
  logic             r_rsp_valid,  w_rsp_valid_nxt;
  logic [WIDTH-1:0] r_rsp_rdata,  w_rsp_rdata_nxt;
  logic [AW-1:0]    r_cnt,        w_cnt_nxt;
  logic [WIDTH-1:0] r_fill_value, w_fill_value_nxt;
  logic             w_req_ready;

  assign w_req_ready = (r_state == S_IDLE) && !bus.init_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ram_we     <= 1'b0;
      r_ram_re     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_cnt        <= '0;
      r_fill_value <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_ram_re     <= w_ram_re_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_din    <= w_ram_din_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fill_value <= w_fill_value_nxt;
    end
  end

  // Strobes default low so every operation ends with a quiet RAM cycle
  always_comb begin
    w_state_nxt      = r_state;
    w_ram_we_nxt     = 1'b0;
    w_ram_re_nxt     = 1'b0;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_din_nxt    = r_ram_din;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    w_cnt_nxt        = r_cnt;
    w_fill_value_nxt = r_fill_value;

    case (r_state)
      S_IDLE: begin
        if (bus.init_start) begin
          // First fill write is issued straight from the accepting edge
          w_fill_value_nxt = bus.init_value;
          w_cnt_nxt        = '0;
          w_ram_we_nxt     = 1'b1;
          w_ram_addr_nxt   = '0;
          w_ram_din_nxt    = bus.init_value;
          w_state_nxt      = S_INIT;
        end else if (bus.req_valid && bus.req_write) begin
          w_ram_we_nxt   = 1'b1;
          w_ram_addr_nxt = bus.req_addr;
          w_ram_din_nxt  = bus.req_wdata;
          w_state_nxt    = S_WR;
        end else if (bus.req_valid) begin
          w_ram_re_nxt   = 1'b1;
          w_ram_addr_nxt = bus.req_addr;
          w_state_nxt    = S_RD;
        end
      end
      S_WR: begin
        w_state_nxt = S_IDLE;
      end
      S_RD: begin
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_rsp_rdata_nxt = bus.ram_data_out;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_RSP;
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      S_INIT: begin
        if (r_cnt == c_last_addr) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt      = r_cnt + AW'(1);
          w_ram_we_nxt   = 1'b1;
          w_ram_addr_nxt = r_cnt + AW'(1);
          w_ram_din_nxt  = r_fill_value;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready        = w_req_ready;
  assign bus.rsp_valid        = r_rsp_valid;
  assign bus.rsp_rdata        = r_rsp_rdata;
  assign bus.init_busy        = (r_state == S_INIT);
  assign bus.ram_data_in      = r_ram_din;
  assign bus.ram_read_enable  = r_ram_re;
  assign bus.ram_write_enable = r_ram_we;
  assign bus.ram_address      = r_ram_addr;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_ram_access_ctrl
// Purpose  : Directed self-checking bench for ram_access_ctrl with a
//            behavioural single-port RAM (registered read).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_ram_access_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ram_access_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ram_access_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout = '0;
  int               wr_log[$];
  bit               overlap = 1'b0;
  int               checks = 0;
  int               passed = 0;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  always @(posedge clock) begin
    if (bus.ram_write_enable) begin
      mem[bus.ram_address] <= bus.ram_data_in;
      wr_log.push_back(int'(bus.ram_address));
    end
    if (bus.ram_read_enable) dout <= mem[bus.ram_address];
  end
  assign bus.ram_data_out = dout;

  always @(negedge clock) if (bus.ram_read_enable && bus.ram_write_enable) overlap = 1'b1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, output bit to);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_wdata = d;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin to = 1'b0; break; end
      tick();
    end
    tick();
    bus.req_valid = 1'b0;
    tick();
  endtask

  // lat counts edges from acceptance (inclusive) to rsp_valid
  task automatic do_read(input logic [AW-1:0] a, output logic [WIDTH-1:0] d,
                         output int lat, output bit to);
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a;
    to = 1'b1; lat = 0; d = '0;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin to = 1'b0; break; end
      tick();
    end
    tick();
    lat = 1;
    bus.req_valid = 1'b0;
    if (!to) begin
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (bus.rsp_valid) begin to = 1'b0; break; end
        tick();
        lat++;
      end
    end
    d = bus.rsp_rdata;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    tick();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 4'd9;
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.ram_read_enable, bus.ram_address} !== {1'b1, 4'd9})
      $display("FAIL reset_pre_read: re/addr=%b/%0d want 1/9", bus.ram_read_enable, bus.ram_address);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.ram_read_enable, bus.ram_write_enable, bus.rsp_valid, bus.init_busy,
         bus.ram_address, bus.ram_data_in, bus.rsp_rdata} !== '0)
      $display("FAIL reset_outputs: re=%b we=%b rv=%b busy=%b addr=%0d din=%h rd=%h want all 0",
               bus.ram_read_enable, bus.ram_write_enable, bus.rsp_valid, bus.init_busy,
               bus.ram_address, bus.ram_data_in, bus.rsp_rdata);
    else passed++;
    @(negedge clock) reset = 1'b1;
    tick();
    checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: req_ready=%b want 1", bus.req_ready);
    else passed++;
  endtask

  task automatic test_write_read();
    logic [WIDTH-1:0] d; int lat; bit to;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 4'd3; bus.req_wdata = 8'hA5;
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.ram_write_enable, bus.ram_read_enable, bus.ram_address, bus.ram_data_in, bus.req_ready}
        !== {1'b1, 1'b0, 4'd3, 8'hA5, 1'b0})
      $display("FAIL wr_strobe: we=%b re=%b addr=%0d din=%h rdy=%b want 1 0 3 a5 0",
               bus.ram_write_enable, bus.ram_read_enable, bus.ram_address, bus.ram_data_in, bus.req_ready);
    else passed++;
    tick();
    checks++;
    if ({bus.ram_write_enable, bus.req_ready} !== 2'b01)
      $display("FAIL wr_done: we=%b rdy=%b want 0 1", bus.ram_write_enable, bus.req_ready);
    else passed++;
    do_read(4'd3, d, lat, to);
    checks++;
    if (to || d !== 8'hA5) $display("FAIL rd_data: data=%h timeout=%b want a5", d, to);
    else passed++;
    checks++;
    if (lat !== 3) $display("FAIL rd_latency: edges=%0d want 3", lat);
    else passed++;
    checks++;
    if (overlap !== 1'b0) $display("FAIL strobe_overlap: overlap=%b want 0", overlap);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit to;
    do_write(4'd0, 8'h5E, to);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 4'd0;
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready} !== {1'b1, 8'h5E, 1'b0})
        $display("FAIL bp_hold[%0d]: rv=%b rd=%h rdy=%b want 1 5e 0 (to=%b)",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, to);
      else passed++;
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.rsp_rdata} !== {1'b0, 1'b1, 8'h5E})
      $display("FAIL bp_release: rv=%b rdy=%b rd=%h want 0 1 5e",
               bus.rsp_valid, bus.req_ready, bus.rsp_rdata);
    else passed++;
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] d; int lat; bit to; int n; bit order_ok;
    wr_log.delete();
    bus.init_value = 8'h3C; bus.init_start = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL fill_ready: req_ready=%b want 0", bus.req_ready);
    else passed++;
    tick();
    bus.init_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.init_busy) break;
      n++;
      tick();
    end
    checks++;
    if (n !== DEPTH) $display("FAIL fill_busy_len: cycles=%0d want %0d", n, DEPTH);
    else passed++;
    order_ok = (wr_log.size() == DEPTH);
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != i) order_ok = 1'b0;
    checks++;
    if (!order_ok) $display("FAIL fill_order: writes=%0d in order=%b want 16 in order", wr_log.size(), order_ok);
    else passed++;
    do_read(4'd0, d, lat, to);
    checks++;
    if (to || d !== 8'h3C) $display("FAIL fill_rd0: data=%h want 3c", d);
    else passed++;
    do_read(4'd15, d, lat, to);
    checks++;
    if (to || d !== 8'h3C) $display("FAIL fill_rd15: data=%h want 3c", d);
    else passed++;
  endtask

  task automatic test_priority();
    logic [WIDTH-1:0] d; int lat; bit to;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 4'd5; bus.req_wdata = 8'h11;
    bus.init_value = 8'h3C; bus.init_start = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL prio_ready: req_ready=%b want 0", bus.req_ready);
    else passed++;
    tick();
    bus.init_start = 1'b0;
    checks++;
    if ({bus.init_busy, bus.ram_address, bus.ram_data_in} !== {1'b1, 4'd0, 8'h3C})
      $display("FAIL prio_fill: busy=%b addr=%0d din=%h want 1 0 3c",
               bus.init_busy, bus.ram_address, bus.ram_data_in);
    else passed++;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.req_ready) begin to = 1'b0; break; end
      tick();
    end
    tick();
    bus.req_valid = 1'b0;
    tick();
    do_read(4'd5, d, lat, to);
    checks++;
    if (to || d !== 8'h11) $display("FAIL prio_rd5: data=%h want 11", d);
    else passed++;
  endtask

  task automatic test_reset_fill();
    logic [WIDTH-1:0] d; int lat; bit to;
    bus.init_value = 8'h77; bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    repeat (7) tick();
    checks++;
    if ({bus.ram_write_enable, bus.ram_address, bus.ram_data_in} !== {1'b1, 4'd7, 8'h77})
      $display("FAIL rfill_cnt7: we=%b addr=%0d din=%h want 1 7 77",
               bus.ram_write_enable, bus.ram_address, bus.ram_data_in);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.ram_write_enable, bus.ram_read_enable, bus.init_busy, bus.ram_address} !== '0)
      $display("FAIL rfill_abort: we=%b re=%b busy=%b addr=%0d want 0 0 0 0",
               bus.ram_write_enable, bus.ram_read_enable, bus.init_busy, bus.ram_address);
    else passed++;
    @(negedge clock) reset = 1'b1;
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      if (a == 7) continue;
      do_read(AW'(a), d, lat, to);
      checks++;
      if (to || d !== ((a < 7) ? 8'h77 : 8'h3C))
        $display("FAIL rfill_rd[%0d]: data=%h want %h", a, d, (a < 7) ? 8'h77 : 8'h3C);
      else passed++;
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; bus.init_start = 1'b0; bus.init_value = '0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_fill();
    test_priority();
    test_reset_fill();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end
endmodule
`default_nettype wire
